// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: ALU writes plus an in-order load queue with starvation control.
// Optional WB_SCOREBOARD_EN adds pend_mask, the set of registers with queued load writes.
module reg_wb_arbiter #(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [31:0]                 alu_data,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [4:0]                  ld_rd,
  input  logic [31:0]                 ld_data,
  output logic                        ld_ready,
  output logic [4:0]                  A3,
  output logic [31:0]                 WD3,
  output logic                        WE3,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [31:0]                 pend_mask
`endif
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rd_q   [LQ_DEPTH];
  logic [31:0]   data_q [LQ_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          empty;
  logic          full;
  logic          force_ld;
  logic          alu_win;
  logic          pop;
  logic          push;
  logic          sel;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  assign empty    = (count == '0);
  assign full     = (count == CW'(LQ_DEPTH));
  assign force_ld = (starve == SW'(STARVE_MAX)) && !empty;
  assign alu_win  = !force_ld && alu_valid;
  assign pop      = force_ld || (!alu_valid && !empty);
  assign push     = ld_valid && !full;
  assign sel      = alu_win || pop;

  assign alu_ready = !force_ld;
  assign ld_ready  = !full;
  assign lq_count  = count;

  always_comb begin
    sel_rd   = rd_q[head];
    sel_data = data_q[head];
    if (alu_win) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // Storage carries no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= ld_rd;
      data_q[tail] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (pop || empty) begin
      starve <= '0;
    end else if (alu_win && starve != SW'(STARVE_MAX)) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A3  <= '0;
      WD3 <= '0;
      WE3 <= 1'b0;
    end else begin
      WE3 <= sel && (sel_rd != 5'd0);
      if (sel) begin
        A3  <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      if (CW'(k) < count)
        pend_mask[rd_q[head + AW'(k)]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter against a queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [2:0]  lq_count;
`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_mask;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic [36:0] mq[$];
  int          m_starve = 0;
  logic [4:0]  e_a3  = '0;
  logic [31:0] e_wd3 = '0;
  logic        e_we3 = 1'b0;

  reg_wb_arbiter #(.LQ_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .lq_count(lq_count)
`ifdef WB_SCOREBOARD_EN
    , .pend_mask(pend_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i][36:32]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    e_a3 = '0; e_wd3 = '0; e_we3 = 1'b0;
  endtask

  // one cycle: drive just after negedge, check combinational outputs,
  // advance the model across the edge, check registered outputs
  task automatic cycle(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ldd);
    bit was_empty, frc, popped, alu_w;
    logic [36:0] item;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    #1;
    was_empty = (mq.size() == 0);
    frc = (m_starve == 3) && !was_empty;
    check("alu_ready", {31'd0, alu_ready}, {31'd0, !frc});
    check("ld_ready", {31'd0, ld_ready}, {31'd0, mq.size() < 4});
    check("lq_count_pre", {29'd0, lq_count}, mq.size());
`ifdef WB_SCOREBOARD_EN
    check("pend_mask", pend_mask, model_mask());
`endif
    popped = frc || (!av && !was_empty);
    alu_w  = !frc && av;
    e_we3  = 1'b0;
    if (popped) begin
      item  = mq.pop_front();
      e_a3  = item[36:32];
      e_wd3 = item[31:0];
      e_we3 = (item[36:32] != 5'd0);
    end else if (alu_w) begin
      e_a3  = ard;
      e_wd3 = ad;
      e_we3 = (ard != 5'd0);
    end
    if (lv && (mq.size() + (popped ? 1 : 0)) < 4) mq.push_back({lrd, ldd});
    if (popped || was_empty) m_starve = 0;
    else if (alu_w && m_starve < 3) m_starve++;
    @(posedge clk); #1;
    check("WE3", {31'd0, WE3}, {31'd0, e_we3});
    check("A3", {27'd0, A3}, {27'd0, e_a3});
    check("WD3", WD3, e_wd3);
    check("lq_count_post", {29'd0, lq_count}, mq.size());
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_WE3", {31'd0, WE3}, 32'd0);
    check("rst_A3", {27'd0, A3}, 32'd0);
    check("rst_WD3", WD3, 32'd0);
    check("rst_lq_count", {29'd0, lq_count}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ALU only
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    check("alu_we3", {31'd0, WE3}, 32'd1);
    check("alu_wd3", WD3, 32'hDEADBEEF);
    cycle(1, 5'd0, 32'h12345678, 0, 0, 0);
    check("alu_x0_we3", {31'd0, WE3}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);

    // loads back to back: writes land 2 and 3 cycles after first push
    cycle(0, 0, 0, 1, 5'd7, 32'h11);
    cycle(0, 0, 0, 1, 5'd8, 32'h22);
    check("ld_first_a3", {27'd0, A3}, 32'd7);
    cycle(0, 0, 0, 0, 0, 0);
    check("ld_second_a3", {27'd0, A3}, 32'd8);
    cycle(0, 0, 0, 0, 0, 0);

    // starvation: ALU held high with one queued load
    cycle(1, 5'd1, 32'hA0, 1, 5'd9, 32'h99);
    for (int i = 0; i < 3; i++) cycle(1, 5'd2, 32'hB0 + i, 0, 0, 0);
    check("starve_force", {31'd0, alu_ready}, 32'd0);
    cycle(1, 5'd3, 32'hC0, 0, 0, 0);
    check("starve_load_a3", {27'd0, A3}, 32'd9);
    cycle(1, 5'd4, 32'hC1, 0, 0, 0);
    check("starve_resume", {27'd0, A3}, 32'd4);

    // full queue under ALU saturation, then pop+push at 3
    for (int i = 0; i < 4; i++) cycle(1, 5'd10, i, 1, 5'(20 + i), 32'h100 + i);
    check("full_ready", {31'd0, ld_ready}, 32'd0);
    cycle(1, 5'd10, 32'h5, 1, 5'd30, 32'h555);
    check("full_count", {29'd0, lq_count}, 32'd3);
    cycle(0, 0, 0, 1, 5'd31, 32'h666);
    check("pop_push_count", {29'd0, lq_count}, 32'd3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

`ifdef WB_SCOREBOARD_EN
    cycle(1, 5'd1, 32'h1, 1, 5'd3, 32'h33);
    cycle(1, 5'd1, 32'h2, 1, 5'd0, 32'h44);
    #1;
    check("sb_mask", pend_mask, 32'h8);
    cycle(0, 0, 0, 0, 0, 0);
    #1;
    check("sb_mask_pop", pend_mask, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
`endif

    // async reset with three entries queued
    for (int i = 0; i < 3; i++) cycle(1, 5'd11, i, 1, 5'(12 + i), 32'hF0 + i);
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_WE3", {31'd0, WE3}, 32'd0);
    check("arst_count", {29'd0, lq_count}, 32'd0);
    check("arst_ld_ready", {31'd0, ld_ready}, 32'd1);
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
